// File: rtl/imm_decode_stage_pkg.sv
// Shared RISC-V opcode and immediate-format definitions.
// Used by fetch/decode stages that handle raw instruction words.
package imm_decode_stage_pkg;

  localparam logic [4:0] OPC_LOAD_5     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM_5 = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM_5   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC_5    = 5'b00101;
  localparam logic [4:0] OPC_STORE_5    = 5'b01000;
  localparam logic [4:0] OPC_OP_5       = 5'b01100;
  localparam logic [4:0] OPC_LUI_5      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH_5   = 5'b11000;
  localparam logic [4:0] OPC_JALR_5     = 5'b11001;
  localparam logic [4:0] OPC_JAL_5      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM_5   = 5'b11100;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  localparam logic [2:0] IMM_FMT_NONE  = 3'd0;
  localparam logic [2:0] IMM_FMT_I     = 3'd1;
  localparam logic [2:0] IMM_FMT_S     = 3'd2;
  localparam logic [2:0] IMM_FMT_B     = 3'd3;
  localparam logic [2:0] IMM_FMT_U     = 3'd4;
  localparam logic [2:0] IMM_FMT_J     = 3'd5;
  localparam logic [2:0] IMM_FMT_SHAMT = 3'd6;
  localparam logic [2:0] IMM_FMT_CSRZ  = 3'd7;

endpackage

// File: rtl/imm_decode_stage_if.sv
// Valid/ready bundle between fetch and the immediate decode stage.
// master = producer/consumer side, slave = the stage.
interface imm_decode_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_inst, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt,
    input  out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_inst, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt,
    output out_illegal, out_tag
  );
endinterface

// File: rtl/imm_decode_stage_extract.sv
// Combinational immediate extraction from a 32-bit instruction word.
// Every input pattern maps to a defined (imm, fmt, illegal) triple.
module imm_extract
  import imm_decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);
  logic [4:0] opc;
  logic [2:0] f3;
  logic       ok, is_shf;
  logic       is_i, is_sh, is_s, is_b;
  logic       is_u, is_j, is_csrz, is_none;
  logic [5:0] sh;

  logic signed [11:0] i_imm, s_imm;
  logic signed [12:0] b_imm;
  logic signed [20:0] j_imm;
  logic signed [31:0] u_imm;

  assign opc = inst[6:2];
  assign f3  = inst[14:12];
  assign ok  = inst[1:0] == 2'b11;

  assign is_shf = f3 == F3_SLL || f3 == F3_SRX;

  assign is_i = ok && (opc == OPC_JALR_5 ||
                opc == OPC_LOAD_5 ||
                (opc == OPC_OP_IMM_5 && !is_shf));
  assign is_sh = ok && opc == OPC_OP_IMM_5 && is_shf;
  assign is_s  = ok && opc == OPC_STORE_5;
  assign is_b  = ok && opc == OPC_BRANCH_5;
  assign is_j  = ok && opc == OPC_JAL_5;
  assign is_u  = ok && (opc == OPC_LUI_5 ||
                 opc == OPC_AUIPC_5);
  assign is_csrz = ok && opc == OPC_SYSTEM_5 && f3[2];
  assign is_none = ok && (opc == OPC_OP_5 ||
                   opc == OPC_MISC_MEM_5 ||
                   (opc == OPC_SYSTEM_5 && !f3[2]));

  assign i_imm = inst[31:20];
  assign s_imm = {inst[31:25], inst[11:7]};
  assign b_imm = {inst[31], inst[7], inst[30:25],
                  inst[11:8], 1'b0};
  assign j_imm = {inst[31], inst[19:12], inst[20],
                  inst[30:21], 1'b0};
  assign u_imm = {inst[31:12], 12'b0};

  // RV64 shifts carry a 6-bit amount; inst[30] is the SRA select.
  assign sh = (XLEN == 64) ? inst[25:20]
                           : {1'b0, inst[24:20]};

  always_comb begin
    imm     = '0;
    fmt     = IMM_FMT_NONE;
    illegal = 1'b0;
    unique case (1'b1)
      is_i: begin
        imm = XLEN'(i_imm);
        fmt = IMM_FMT_I;
      end
      is_sh: begin
        imm = XLEN'(sh);
        fmt = IMM_FMT_SHAMT;
      end
      is_s: begin
        imm = XLEN'(s_imm);
        fmt = IMM_FMT_S;
      end
      is_b: begin
        imm = XLEN'(b_imm);
        fmt = IMM_FMT_B;
      end
      is_u: begin
        imm = XLEN'(u_imm);
        fmt = IMM_FMT_U;
      end
      is_j: begin
        imm = XLEN'(j_imm);
        fmt = IMM_FMT_J;
      end
      is_csrz: begin
        imm = XLEN'(inst[19:15]);
        fmt = IMM_FMT_CSRZ;
      end
      is_none: illegal = 1'b0;
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate decode stage with optional 2-entry skid buffer.
// Flush drops every buffered beat; reset clears data as well.
module imm_decode_stage
  import imm_decode_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int SKID  = 1,
  parameter int TAG_W = 32
) (
  input logic clk,
  input logic rst,
  input logic flush,
  imm_decode_stage_if.slave io
);
  localparam int W = XLEN + 4 + TAG_W;

  logic [XLEN-1:0] x_imm;
  logic [2:0]      x_fmt;
  logic            x_ill;
  logic [W-1:0]    nbeat, obeat;
  logic            ov, rdy, acc, emit;

  imm_extract #(.XLEN(XLEN)) u_ext (
    .inst    (io.in_inst),
    .imm     (x_imm),
    .fmt     (x_fmt),
    .illegal (x_ill)
  );

  assign nbeat = {x_imm, x_fmt, x_ill, io.in_tag};
  assign acc   = io.in_valid && rdy;
  assign emit  = ov && io.out_ready;

  assign io.in_ready  = rdy;
  assign io.out_valid = ov;
  assign {io.out_imm, io.out_fmt,
          io.out_illegal, io.out_tag} = obeat;

  if (SKID != 0) begin : g_skid
    logic         sv;
    logic [W-1:0] sbeat;

    // Ready only depends on state, so out_ready never reaches in_ready.
    assign rdy = !sv;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ov    <= 1'b0;
        obeat <= '0;
        sv    <= 1'b0;
        sbeat <= '0;
      end else if (flush) begin
        ov <= 1'b0;
        sv <= 1'b0;
      end else if (sv) begin
        if (emit) begin
          obeat <= sbeat;
          sv    <= 1'b0;
        end
      end else if (acc) begin
        if (!ov || emit) begin
          obeat <= nbeat;
          ov    <= 1'b1;
        end else begin
          sbeat <= nbeat;
          sv    <= 1'b1;
        end
      end else if (emit) begin
        ov <= 1'b0;
      end
    end
  end else begin : g_noskid
    assign rdy = !ov || io.out_ready;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ov    <= 1'b0;
        obeat <= '0;
      end else if (flush) begin
        ov <= 1'b0;
      end else if (acc) begin
        obeat <= nbeat;
        ov    <= 1'b1;
      end else if (emit) begin
        ov <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench: RV32 skid instance and RV64 no-skid instance.
module tb_imm_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  imm_decode_stage_if #(.XLEN(32), .TAG_W(32)) a_if ();
  imm_decode_stage_if #(.XLEN(64), .TAG_W(32)) b_if ();

  imm_decode_stage #(.XLEN(32), .SKID(1), .TAG_W(32)) ua (
    .clk(clk), .rst(rst), .flush(flush), .io(a_if)
  );
  imm_decode_stage #(.XLEN(64), .SKID(0), .TAG_W(32)) ub (
    .clk(clk), .rst(rst), .flush(flush), .io(b_if)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer_a(input logic [31:0] inst,
                         input logic [31:0] tag);
    a_if.in_valid = 1'b1;
    a_if.in_inst  = inst;
    a_if.in_tag   = tag;
  endtask

  task automatic offer_b(input logic [31:0] inst,
                         input logic [31:0] tag);
    b_if.in_valid = 1'b1;
    b_if.in_inst  = inst;
    b_if.in_tag   = tag;
  endtask

  task automatic chk_a(input string tag,
                       input logic [31:0] imm,
                       input logic [2:0] fmt,
                       input logic [31:0] t);
    chk({tag, "_v"}, 64'(a_if.out_valid), 64'd1);
    chk({tag, "_imm"}, 64'(a_if.out_imm), 64'(imm));
    chk({tag, "_fmt"}, 64'(a_if.out_fmt), 64'(fmt));
    chk({tag, "_tag"}, 64'(a_if.out_tag), 64'(t));
  endtask

  task automatic chk_b(input string tag,
                       input logic [63:0] imm,
                       input logic [2:0] fmt,
                       input logic ill);
    chk({tag, "_v"}, 64'(b_if.out_valid), 64'd1);
    chk({tag, "_imm"}, b_if.out_imm, imm);
    chk({tag, "_fmt"}, 64'(b_if.out_fmt), 64'(fmt));
    chk({tag, "_ill"}, 64'(b_if.out_illegal), 64'(ill));
  endtask

  initial begin
    a_if.in_valid = 1'b0; a_if.in_inst = '0;
    a_if.in_tag = '0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_inst = '0;
    b_if.in_tag = '0; b_if.out_ready = 1'b0;

    tick();
    chk("rst_ov", 64'(a_if.out_valid), 64'd0);
    chk("rst_imm", 64'(a_if.out_imm), 64'd0);
    chk("rst_fmt", 64'(a_if.out_fmt), 64'd0);
    chk("rst_ill", 64'(a_if.out_illegal), 64'd0);
    chk("rst_tag", 64'(a_if.out_tag), 64'd0);
    chk("rst_rdy", 64'(a_if.in_ready), 64'd1);
    chk("rst_rdy_b", 64'(b_if.in_ready), 64'd1);
    rst = 1'b0;

    // RV32 back-to-back at full rate
    a_if.out_ready = 1'b1;
    offer_a(32'hFFF00093, 32'd10);
    tick();
    chk_a("addi", 32'hFFFFFFFF, 3'd1, 32'd10);
    offer_a(32'h4030D093, 32'd11);
    tick();
    chk_a("srai", 32'h00000003, 3'd6, 32'd11);
    offer_a(32'hFE000EE3, 32'd12);
    tick();
    chk_a("beq", 32'hFFFFFFFC, 3'd3, 32'd12);
    a_if.in_valid = 1'b0;
    tick();
    chk("drain_ov", 64'(a_if.out_valid), 64'd0);

    // RV64, no skid
    b_if.out_ready = 1'b1;
    offer_b(32'h800000B7, 32'd1);
    tick();
    chk_b("lui64", 64'hFFFFFFFF80000000, 3'd4, 1'b0);
    offer_b(32'h0FF0B093, 32'd2);
    tick();
    chk_b("sltiu64", 64'h00000000000000FF, 3'd1, 1'b0);
    offer_b(32'h005FD073, 32'd3);
    tick();
    chk_b("csrrwi", 64'd31, 3'd7, 1'b0);
    offer_b(32'h0000007F, 32'd4);
    tick();
    chk_b("badopc", 64'd0, 3'd0, 1'b1);
    b_if.in_valid = 1'b0;
    b_if.out_ready = 1'b0;
    #1;
    chk("b_rdy_stall", 64'(b_if.in_ready), 64'd0);
    b_if.out_ready = 1'b1;
    #1;
    chk("b_rdy_comb", 64'(b_if.in_ready), 64'd1);
    tick();
    chk("b_drain", 64'(b_if.out_valid), 64'd0);

    // Skid: stall with tags 1,2,3
    a_if.out_ready = 1'b0;
    offer_a(32'hFFF00093, 32'd1);
    tick();
    chk_a("st1", 32'hFFFFFFFF, 3'd1, 32'd1);
    chk("st1_rdy", 64'(a_if.in_ready), 64'd1);
    offer_a(32'h4030D093, 32'd2);
    tick();
    chk_a("st2", 32'hFFFFFFFF, 3'd1, 32'd1);
    chk("st2_rdy", 64'(a_if.in_ready), 64'd0);
    offer_a(32'hFE000EE3, 32'd3);
    tick();
    chk_a("st3", 32'hFFFFFFFF, 3'd1, 32'd1);
    chk("st3_rdy", 64'(a_if.in_ready), 64'd0);
    a_if.out_ready = 1'b1;
    tick();
    chk_a("em2", 32'h00000003, 3'd6, 32'd2);
    chk("em2_rdy", 64'(a_if.in_ready), 64'd1);
    tick();
    chk_a("em3", 32'hFFFFFFFC, 3'd3, 32'd3);
    a_if.in_valid = 1'b0;
    tick();
    chk("em_done", 64'(a_if.out_valid), 64'd0);

    // Flush with two buffered beats
    a_if.out_ready = 1'b0;
    offer_a(32'hFFF00093, 32'd4);
    tick();
    offer_a(32'hFFF00093, 32'd5);
    tick();
    chk("fl_full", 64'(a_if.in_ready), 64'd0);
    offer_a(32'h4030D093, 32'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    a_if.in_valid = 1'b0;
    chk("fl_ov", 64'(a_if.out_valid), 64'd0);
    chk("fl_rdy", 64'(a_if.in_ready), 64'd1);
    a_if.out_ready = 1'b1;
    offer_a(32'hFE000EE3, 32'd7);
    tick();
    chk_a("fl_next", 32'hFFFFFFFC, 3'd3, 32'd7);
    a_if.in_valid = 1'b0;
    tick();
    chk("fl_alone", 64'(a_if.out_valid), 64'd0);

    // Flush drops a beat accepted in the flush cycle
    a_if.out_ready = 1'b0;
    offer_a(32'hFFF00093, 32'd8);
    tick();
    offer_a(32'hFFF00093, 32'd9);
    chk("fl2_rdy", 64'(a_if.in_ready), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    a_if.in_valid = 1'b0;
    chk("fl2_ov", 64'(a_if.out_valid), 64'd0);
    tick();
    chk("fl2_drop", 64'(a_if.out_valid), 64'd0);

    // Asynchronous reset with a stalled output
    offer_a(32'hFE000EE3, 32'd20);
    tick();
    chk("ar_pre", 64'(a_if.out_valid), 64'd1);
    a_if.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_ov", 64'(a_if.out_valid), 64'd0);
    chk("ar_imm", 64'(a_if.out_imm), 64'd0);
    chk("ar_fmt", 64'(a_if.out_fmt), 64'd0);
    chk("ar_tag", 64'(a_if.out_tag), 64'd0);
    tick();
    rst = 1'b0;
    a_if.out_ready = 1'b1;
    offer_a(32'h4030D093, 32'd21);
    tick();
    chk_a("ar_first", 32'h00000003, 3'd6, 32'd21);
    a_if.in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
